axi_sram_slave: RTL and testbench

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

---
 rtl/axi_sram_if.sv | 71 +++++++
 rtl/axi_sram_slave.sv | 176 +++++++++++++++++
 tb/tb_axi_sram_slave.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_if.sv
// AXI3-style bus bundle between a master and the SRAM slave.
interface axi_sram_if #(
    parameter int unsigned ID_W = 4
);
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [1:0]      arburst;
    logic [2:0]      arsize;
    logic [1:0]      arlock;
    logic [3:0]      arcache;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [1:0]      awburst;
    logic [2:0]      awsize;
    logic [1:0]      awlock;
    logic [3:0]      awcache;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;

    logic [ID_W-1:0] wid;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output arid, araddr, arlen, arburst, arsize, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awburst, awsize, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arburst, arsize, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awburst, awsize, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// Single-port 32-bit SRAM behind an AXI slave; one read or write burst in flight at a time.
module axi_sram_slave #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned ID_W   = 4
) (
    input  logic       aclk,
    input  logic       aresetn,
    axi_sram_if.slave  axi
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

    state_t state_q, state_d;

    logic [31:0] mem [DEPTH];

    logic [ID_W-1:0]   rid_q;
    logic [31:0]       rdata_q;
    logic              rvalid_q;
    logic              rlast_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [7:0]        rd_len_q;
    logic [1:0]        rd_burst_q;
    logic [7:0]        rd_beat_q;

    logic [ID_W-1:0]   bid_q;
    logic [1:0]        bresp_q;
    logic              bvalid_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_len_q;
    logic [1:0]        wr_burst_q;
    logic [7:0]        wr_cnt_q;
    logic              wr_over_q;

    logic ar_hs, aw_hs, r_hs, w_hs, b_hs;
    logic [ADDR_W-1:0] ar_idx, aw_idx, rd_next, wr_next;

    // Word address of the following beat; WRAP uses len as the in-window mask (len 1/3/7/15).
    function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [1:0]        burst,
                                                    input logic [7:0]        len);
        logic [ADDR_W-1:0] mask;
        mask = ADDR_W'(len);
        case (burst)
            2'b00:   step_addr = a;
            2'b10:   step_addr = (a & ~mask) | ((a + ADDR_W'(1)) & mask);
            default: step_addr = a + ADDR_W'(1);
        endcase
    endfunction

    assign ar_idx  = axi.araddr[ADDR_W+1:2];
    assign aw_idx  = axi.awaddr[ADDR_W+1:2];
    assign rd_next = step_addr(rd_addr_q, rd_burst_q, rd_len_q);
    assign wr_next = step_addr(wr_addr_q, wr_burst_q, wr_len_q);

    assign ar_hs = (state_q == IDLE) && axi.arvalid;
    assign aw_hs = (state_q == IDLE) && !axi.arvalid && axi.awvalid;
    assign r_hs  = (state_q == RD) && rvalid_q && axi.rready;
    assign w_hs  = (state_q == WR) && axi.wvalid;
    assign b_hs  = (state_q == WRESP) && bvalid_q && axi.bready;

    // Ready strobes decode straight from the state register; reads win a same-cycle tie.
    assign axi.arready = (state_q == IDLE);
    assign axi.awready = (state_q == IDLE) && !axi.arvalid;
    assign axi.wready  = (state_q == WR);

    assign axi.rid    = rid_q;
    assign axi.rdata  = rdata_q;
    assign axi.rresp  = 2'b00;
    assign axi.rlast  = rlast_q;
    assign axi.rvalid = rvalid_q;
    assign axi.bid    = bid_q;
    assign axi.bresp  = bresp_q;
    assign axi.bvalid = bvalid_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ar_hs)      state_d = RD;
                else if (aw_hs) state_d = WR;
            end
            RD:      if (r_hs && rlast_q)   state_d = IDLE;
            WR:      if (w_hs && axi.wlast) state_d = WRESP;
            WRESP:   if (b_hs)              state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read channel: the next beat is fetched on the handshake so rvalid can stay high.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rid_q      <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_len_q   <= '0;
            rd_burst_q <= '0;
            rd_beat_q  <= '0;
        end else if (ar_hs) begin
            rid_q      <= axi.arid;
            rd_addr_q  <= ar_idx;
            rd_len_q   <= axi.arlen;
            rd_burst_q <= axi.arburst;
            rd_beat_q  <= '0;
            rdata_q    <= mem[ar_idx];
            rvalid_q   <= 1'b1;
            rlast_q    <= (axi.arlen == 8'd0);
        end else if (r_hs) begin
            if (rlast_q) begin
                rvalid_q <= 1'b0;
                rlast_q  <= 1'b0;
            end else begin
                rd_addr_q <= rd_next;
                rdata_q   <= mem[rd_next];
                rd_beat_q <= rd_beat_q + 8'd1;
                rlast_q   <= ((rd_beat_q + 8'd1) == rd_len_q);
            end
        end
    end

    // Write channel: beats past awlen are dropped and latched as an error until wlast.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bid_q      <= '0;
            bresp_q    <= 2'b00;
            bvalid_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_len_q   <= '0;
            wr_burst_q <= '0;
            wr_cnt_q   <= '0;
            wr_over_q  <= 1'b0;
        end else if (aw_hs) begin
            bid_q      <= axi.awid;
            wr_addr_q  <= aw_idx;
            wr_len_q   <= axi.awlen;
            wr_burst_q <= axi.awburst;
            wr_cnt_q   <= '0;
            wr_over_q  <= 1'b0;
        end else if (w_hs) begin
            wr_addr_q <= wr_next;
            if (axi.wlast) begin
                bvalid_q <= 1'b1;
                bresp_q  <= (!wr_over_q && (wr_cnt_q == wr_len_q)) ? 2'b00 : 2'b10;
            end else if (wr_cnt_q == wr_len_q) begin
                wr_over_q <= 1'b1;
            end else begin
                wr_cnt_q <= wr_cnt_q + 8'd1;
            end
        end else if (b_hs) begin
            bvalid_q <= 1'b0;
        end
    end

    // Storage has no reset so completed writes survive aresetn.
    always_ff @(posedge aclk) begin
        if (w_hs && !wr_over_q) begin
            for (int i = 0; i < 4; i++) begin
                if (axi.wstrb[i]) mem[wr_addr_q][8*i +: 8] <= axi.wdata[8*i +: 8];
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^{axi.araddr[31:ADDR_W+2], axi.araddr[1:0],
                         axi.awaddr[31:ADDR_W+2], axi.awaddr[1:0],
                         axi.arsize, axi.arlock, axi.arcache, axi.arprot,
                         axi.awsize, axi.awlock, axi.awcache, axi.awprot, axi.wid};
endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized bench for axi_sram_slave against a word-array memory model.
module tb_axi_sram_slave;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned DEPTH  = 1024;

    logic aclk;
    logic aresetn;

    axi_sram_if #(.ID_W(ID_W)) axi ();

    axi_sram_slave #(.ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .axi     (axi)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Word index touched by beat i of a burst, from byte-address arithmetic.
    function automatic int unsigned beat_word(input logic [31:0] a, input int len,
                                              input logic [1:0] burst, input int i);
        longint unsigned la, sz, base, ba;
        la = 64'(a);
        if (burst == 2'b00) begin
            ba = la;
        end else if (burst == 2'b10) begin
            sz   = 64'((len + 1) * 4);
            base = (la / sz) * sz;
            ba   = base + ((la - base) + 64'(4 * i)) % sz;
        end else begin
            ba = la + 64'(4 * i);
        end
        return 32'((ba / 64'd4) % 64'(DEPTH));
    endfunction

    task automatic fill_wd(input bit rand_strb);
        for (int k = 0; k < 256; k++) begin
            wd[k] = $urandom;
            ws[k] = rand_strb ? 4'($urandom_range(0, 15)) : 4'hF;
        end
    endtask

    task automatic aw_phase(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst);
        int cyc;
        bit hs;
        axi.awid = id; axi.awaddr = addr; axi.awlen = 8'(len); axi.awburst = burst;
        axi.awsize = 3'd2; axi.awvalid = 1'b1;
        hs = 1'b0; cyc = 0;
        while (!hs && cyc < 100) begin
            @(negedge aclk); hs = axi.awready;
            @(posedge aclk); #1; cyc++;
        end
        axi.awvalid = 1'b0;
        if (!hs) chk("aw_timeout", 32'd0, 32'd1);
    endtask

    task automatic w_phase(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input int nb);
        int cyc;
        bit hs;
        int unsigned idx;
        for (int b = 0; b < nb; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                axi.wvalid = 1'b0; @(posedge aclk); #1;
            end
            axi.wvalid = 1'b1; axi.wdata = wd[b]; axi.wstrb = ws[b];
            axi.wlast = (b == nb - 1); axi.wid = 4'($urandom);
            hs = 1'b0; cyc = 0;
            while (!hs && cyc < 100) begin
                @(negedge aclk); hs = axi.wready;
                if (hs && b <= len) begin
                    idx = beat_word(addr, len, burst, b);
                    for (int k = 0; k < 4; k++)
                        if (ws[b][k]) model_mem[idx][8*k +: 8] = wd[b][8*k +: 8];
                end
                @(posedge aclk); #1; cyc++;
            end
            if (!hs) begin chk("w_timeout", 32'd0, 32'd1); break; end
        end
        axi.wvalid = 1'b0; axi.wlast = 1'b0;
    endtask

    task automatic b_phase(input logic [3:0] id, input logic [1:0] resp, input bit rand_ready);
        int cyc;
        bit done;
        done = 1'b0; cyc = 0;
        while (!done && cyc < 200) begin
            axi.bready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge aclk);
            if (axi.bvalid) begin
                chk("bid", 32'(axi.bid), 32'(id));
                chk("bresp", 32'(axi.bresp), 32'(resp));
                if (axi.bready) done = 1'b1;
            end
            @(posedge aclk); #1; cyc++;
        end
        axi.bready = 1'b0;
        if (!done) chk("b_timeout", 32'd0, 32'd1);
        @(negedge aclk); chk("bvalid_drop", 32'(axi.bvalid), 32'd0);
        @(posedge aclk); #1;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input int nb, input bit rand_ready);
        aw_phase(id, addr, len, burst);
        w_phase(addr, len, burst, nb);
        b_phase(id, (nb == len + 1) ? 2'b00 : 2'b10, rand_ready);
    endtask

    task automatic ar_phase(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst);
        int cyc;
        bit hs;
        axi.arid = id; axi.araddr = addr; axi.arlen = 8'(len); axi.arburst = burst;
        axi.arsize = 3'd2; axi.arvalid = 1'b1;
        hs = 1'b0; cyc = 0;
        while (!hs && cyc < 100) begin
            @(negedge aclk); hs = axi.arready;
            @(posedge aclk); #1; cyc++;
        end
        axi.arvalid = 1'b0;
        if (!hs) chk("ar_timeout", 32'd0, 32'd1);
    endtask

    // Starts the cycle after the AR handshake; ends on the negedge after the last beat.
    task automatic r_phase(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input int stall_beat, input bit rand_ready,
                           input bit aw_blk, output logic [31:0] last);
        int i, cyc, stall_left;
        i = 0; cyc = 0; stall_left = 3; last = '0;
        while (i <= len && cyc < 2000) begin
            if (i == stall_beat && stall_left > 0) begin
                axi.rready = 1'b0; stall_left--;
            end else begin
                axi.rready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            @(negedge aclk);
            chk("rvalid", 32'(axi.rvalid), 32'd1);
            chk("rid", 32'(axi.rid), 32'(id));
            chk("rdata", axi.rdata, model_mem[beat_word(addr, len, burst, i)]);
            chk("rlast", 32'(axi.rlast), 32'(i == len));
            chk("rresp", 32'(axi.rresp), 32'd0);
            if (aw_blk) chk("awready_blocked", 32'(axi.awready), 32'd0);
            if (axi.rready) begin last = axi.rdata; i++; end
            @(posedge aclk); #1; cyc++;
        end
        axi.rready = 1'b0;
        if (i <= len) chk("r_timeout", 32'd0, 32'd1);
        @(negedge aclk);
        chk("rvalid_drop", 32'(axi.rvalid), 32'd0);
        chk("rlast_drop", 32'(axi.rlast), 32'd0);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input int stall_beat, input bit rand_ready,
                           output logic [31:0] last);
        ar_phase(id, addr, len, burst);
        r_phase(id, addr, len, burst, stall_beat, rand_ready, 1'b0, last);
        @(posedge aclk); #1;
    endtask

    initial begin
        logic [31:0] last;
        logic [31:0] addr;
        logic [1:0]  burst;
        logic [3:0]  id;
        int len, nb;

        aresetn = 1'b0;
        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arburst = '0; axi.arsize = '0;
        axi.arlock = '0; axi.arcache = '0; axi.arprot = '0; axi.arvalid = 1'b0;
        axi.rready = 1'b0;
        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awburst = '0; axi.awsize = '0;
        axi.awlock = '0; axi.awcache = '0; axi.awprot = '0; axi.awvalid = 1'b0;
        axi.wid = '0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
        axi.bready = 1'b0;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_rvalid", 32'(axi.rvalid), 32'd0);
        chk("rst_bvalid", 32'(axi.bvalid), 32'd0);
        chk("rst_wready", 32'(axi.wready), 32'd0);
        chk("rst_rdata", axi.rdata, 32'd0);
        @(posedge aclk); #1; aresetn = 1'b1;
        @(negedge aclk);
        chk("rel_arready", 32'(axi.arready), 32'd1);
        chk("rel_awready", 32'(axi.awready), 32'd1);
        chk("rel_rvalid", 32'(axi.rvalid), 32'd0);
        chk("rel_bvalid", 32'(axi.bvalid), 32'd0);
        @(posedge aclk); #1;

        // Give every word a known value with maximum-length bursts.
        for (int q = 0; q < 4; q++) begin
            fill_wd(1'b0);
            do_write(4'(q), 32'(q * 1024), 255, 2'b01, 256, 1'b0);
        end

        // Basic INCR write / read-back.
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        for (int k = 0; k < 4; k++) ws[k] = 4'hF;
        do_write(4'd5, 32'h100, 3, 2'b01, 4, 1'b0);
        do_read(4'd3, 32'h100, 3, 2'b01, -1, 1'b0, last);
        chk("incr_last", last, 32'h44);

        do_read(4'd7, 32'h108, 3, 2'b10, -1, 1'b0, last);
        chk("wrap_last", last, 32'h22);

        // Byte-lane merge.
        wd[0] = 32'h11223344; ws[0] = 4'hF;
        do_write(4'd1, 32'h200, 0, 2'b01, 1, 1'b0);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
        do_write(4'd2, 32'h200, 0, 2'b01, 1, 1'b0);
        do_read(4'd2, 32'h200, 0, 2'b01, -1, 1'b0, last);
        chk("strb_merge", last, 32'h11BB33DD);

        // Simultaneous AR and AW in IDLE.
        axi.awid = 4'h9; axi.awaddr = 32'h300; axi.awlen = 8'd0; axi.awburst = 2'b01;
        axi.awvalid = 1'b1;
        axi.arid = 4'h6; axi.araddr = 32'h100; axi.arlen = 8'd3; axi.arburst = 2'b01;
        axi.arvalid = 1'b1;
        @(negedge aclk);
        chk("tie_arready", 32'(axi.arready), 32'd1);
        chk("tie_awready", 32'(axi.awready), 32'd0);
        @(posedge aclk); #1; axi.arvalid = 1'b0;
        r_phase(4'h6, 32'h100, 3, 2'b01, -1, 1'b0, 1'b1, last);
        chk("tie_aw_after", 32'(axi.awready), 32'd1);
        @(posedge aclk); #1; axi.awvalid = 1'b0;
        wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
        w_phase(32'h300, 0, 2'b01, 1);
        b_phase(4'h9, 2'b00, 1'b0);
        do_read(4'h9, 32'h300, 0, 2'b01, -1, 1'b0, last);
        chk("tie_write_data", last, 32'hCAFEF00D);

        // Early wlast and overlong bursts both answer SLVERR.
        fill_wd(1'b0);
        do_write(4'd4, 32'h140, 3, 2'b01, 2, 1'b0);
        fill_wd(1'b0);
        do_write(4'd8, 32'h180, 1, 2'b01, 4, 1'b1);
        do_read(4'd8, 32'h180, 3, 2'b01, -1, 1'b0, last);

        // Three-cycle rready stall in the middle of a burst.
        do_read(4'hA, 32'h100, 7, 2'b01, 2, 1'b0, last);

        // Reset in the middle of a read burst.
        ar_phase(4'd1, 32'h100, 7, 2'b01);
        axi.rready = 1'b1;
        repeat (2) @(posedge aclk);
        #1; aresetn = 1'b0; #1;
        chk("mid_rst_rvalid", 32'(axi.rvalid), 32'd0);
        chk("mid_rst_rlast", 32'(axi.rlast), 32'd0);
        chk("mid_rst_rid", 32'(axi.rid), 32'd0);
        chk("mid_rst_rdata", axi.rdata, 32'd0);
        axi.rready = 1'b0;
        @(posedge aclk); #1; aresetn = 1'b1;
        @(negedge aclk);
        chk("post_rst_arready", 32'(axi.arready), 32'd1);
        chk("post_rst_awready", 32'(axi.awready), 32'd1);
        chk("post_rst_bvalid", 32'(axi.bvalid), 32'd0);
        @(posedge aclk); #1;
        do_read(4'd2, 32'h100, 3, 2'b01, -1, 1'b1, last);

        // Random bursts of every type, each written then read back.
        for (int t = 0; t < 40; t++) begin
            burst = 2'($urandom_range(0, 3));
            len   = (burst == 2'b10) ? ((1 << $urandom_range(1, 4)) - 1) : int'($urandom_range(0, 15));
            addr  = $urandom & 32'hFFFF_FFFC;
            id    = 4'($urandom);
            nb    = len + 1;
            if ($urandom_range(0, 4) == 0) nb = int'($urandom_range(1, 32'(len + 3)));
            fill_wd(1'b1);
            do_write(id, addr, len, burst, nb, 1'b1);
            do_read(~id, addr, len, burst, (t % 5 == 0) ? 1 : -1, 1'b1, last);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
